hazard_ctrl_mc: RTL and testbench

//  Parametrised next-generation hazard unit for the 5-stage MIPS pipeline. Adds D-stage branch-compare

---
 rtl/hazard_ctrl_mc.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc.sv
// Hazard unit for the 5-stage pipeline: EX/D forwarding, load-use/branch/HI-LO stalls, syscall drain FSM.
// Latency: forwards and stalls are combinational; md_busy and syscall_fire come from registered state.
// Backpressure: any hazard raises StallF/StallD/FlushE together; the FSM keeps advancing while stalled.
module hazard_ctrl_mc #(
    parameter int REG_BITS      = 5,
    parameter int MD_LATENCY    = 32,
    parameter int SYSCALL_DRAIN = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [REG_BITS-1:0] RsD,
    input  logic [REG_BITS-1:0] RtD,
    input  logic                UsesRsD,
    input  logic                UsesRtD,
    input  logic                BranchD,
    input  logic                ReadsHiLoD,
    input  logic                syscallD,
    input  logic [REG_BITS-1:0] RsE,
    input  logic [REG_BITS-1:0] RtE,
    input  logic [REG_BITS-1:0] WriteRegE,
    input  logic                RegWriteE,
    input  logic                MemtoRegE,
    input  logic                MdStartE,
    input  logic [REG_BITS-1:0] WriteRegM,
    input  logic                RegWriteM,
    input  logic                MemtoRegM,
    input  logic [REG_BITS-1:0] WriteRegW,
    input  logic                RegWriteW,
    output logic                StallF,
    output logic                StallD,
    output logic                FlushE,
    output logic [1:0]          ForwardAE,
    output logic [1:0]          ForwardBE,
    output logic                ForwardAD,
    output logic                ForwardBD,
    output logic                md_busy,
    output logic                syscall_fire
);

    localparam int MD_W = $clog2(MD_LATENCY + 1);
    localparam int DR_W = $clog2(SYSCALL_DRAIN + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] FIRE  = 2'd2;

    logic [1:0]      state;
    logic [DR_W-1:0] drainCnt;
    logic [MD_W-1:0] mdCnt;
    logic            lwStall;
    logic            brStall;
    logic            hlStall;
    logic            sysStall;

    // $zero is hard-wired, so it can never be a real producer.
    function automatic logic regMatch(input logic [REG_BITS-1:0] a, input logic [REG_BITS-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    assign ForwardAE = (RegWriteM && regMatch(WriteRegM, RsE)) ? 2'b10 :
                       (RegWriteW && regMatch(WriteRegW, RsE)) ? 2'b01 : 2'b00;
    assign ForwardBE = (RegWriteM && regMatch(WriteRegM, RtE)) ? 2'b10 :
                       (RegWriteW && regMatch(WriteRegW, RtE)) ? 2'b01 : 2'b00;
    assign ForwardAD = RegWriteM && regMatch(WriteRegM, RsD);
    assign ForwardBD = RegWriteM && regMatch(WriteRegM, RtD);

    assign lwStall = MemtoRegE && RegWriteE &&
                     ((UsesRsD && regMatch(WriteRegE, RsD)) || (UsesRtD && regMatch(WriteRegE, RtD)));
    assign brStall = BranchD &&
                     ((RegWriteE && (regMatch(WriteRegE, RsD) || regMatch(WriteRegE, RtD))) ||
                      (MemtoRegM && (regMatch(WriteRegM, RsD) || regMatch(WriteRegM, RtD))));
    assign hlStall  = ReadsHiLoD && md_busy;
    assign sysStall = (state != IDLE) || syscallD;

    assign StallF = lwStall || brStall || hlStall || sysStall;
    assign StallD = StallF;
    assign FlushE = StallF;

    assign md_busy      = (mdCnt != '0);
    assign syscall_fire = (state == FIRE);

    // A new mul/div reissue simply restarts the window; HI/LO only holds the newest result.
    always_ff @(posedge clock) begin
        if (reset) begin
            mdCnt <= '0;
        end else if (MdStartE) begin
            mdCnt <= MD_W'(MD_LATENCY);
        end else if (mdCnt != '0) begin
            mdCnt <= mdCnt - MD_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            drainCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (syscallD) begin
                        state    <= DRAIN;
                        drainCnt <= DR_W'(SYSCALL_DRAIN);
                    end
                end
                DRAIN: begin
                    // Drain done: fire only once HI/LO is settled, otherwise park at zero.
                    if (drainCnt <= DR_W'(1)) begin
                        drainCnt <= '0;
                        if (!md_busy) begin
                            state <= FIRE;
                        end
                    end else begin
                        drainCnt <= drainCnt - DR_W'(1);
                    end
                end
                FIRE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc with a cycle-time reference model checked every cycle.
module tb_hazard_ctrl_mc;
    localparam int ML = 4;
    localparam int SD = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       UsesRsD, UsesRtD, BranchD, ReadsHiLoD, syscallD;
    logic       RegWriteE, MemtoRegE, MdStartE, RegWriteM, MemtoRegM, RegWriteW;
    logic       StallF, StallD, FlushE, ForwardAD, ForwardBD, md_busy, syscall_fire;
    logic [1:0] ForwardAE, ForwardBE;

    int passCnt  = 0;
    int totalCnt = 0;

    hazard_ctrl_mc #(.REG_BITS(5), .MD_LATENCY(ML), .SYSCALL_DRAIN(SD)) dut (
        .clock(clock), .reset(reset),
        .RsD(RsD), .RtD(RtD), .UsesRsD(UsesRsD), .UsesRtD(UsesRtD),
        .BranchD(BranchD), .ReadsHiLoD(ReadsHiLoD), .syscallD(syscallD),
        .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
        .MemtoRegE(MemtoRegE), .MdStartE(MdStartE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .md_busy(md_busy), .syscall_fire(syscall_fire)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    // Reference model in absolute cycle time: HI/LO busy window end, syscall start and fire cycle.
    int  cyc        = 0;
    int  mdBusyEnd  = -1;
    int  sysStart   = -1;
    int  fireCycle  = -1;
    bit  armed      = 0;

    always @(negedge clock) begin
        int  expFAE, expFBE;
        bit  expBusy, expFire, lw, br, hl, sy, stall;
        expBusy = (cyc <= mdBusyEnd);
        expFire = (fireCycle == cyc);
        expFAE  = (RegWriteM && hit(WriteRegM, RsE)) ? 2 : (RegWriteW && hit(WriteRegW, RsE)) ? 1 : 0;
        expFBE  = (RegWriteM && hit(WriteRegM, RtE)) ? 2 : (RegWriteW && hit(WriteRegW, RtE)) ? 1 : 0;
        lw = MemtoRegE && RegWriteE &&
             ((UsesRsD && hit(WriteRegE, RsD)) || (UsesRtD && hit(WriteRegE, RtD)));
        br = BranchD && ((RegWriteE && (hit(WriteRegE, RsD) || hit(WriteRegE, RtD))) ||
                         (MemtoRegM && (hit(WriteRegM, RsD) || hit(WriteRegM, RtD))));
        hl = ReadsHiLoD && expBusy;
        sy = (sysStart >= 0) || syscallD;
        stall = lw || br || hl || sy;
        if (armed) begin
            check("m_ForwardAE", ForwardAE, expFAE);
            check("m_ForwardBE", ForwardBE, expFBE);
            check("m_ForwardAD", ForwardAD, int'(RegWriteM && hit(WriteRegM, RsD)));
            check("m_ForwardBD", ForwardBD, int'(RegWriteM && hit(WriteRegM, RtD)));
            check("m_StallF", StallF, int'(stall));
            check("m_StallD", StallD, int'(stall));
            check("m_FlushE", FlushE, int'(stall));
            check("m_md_busy", md_busy, int'(expBusy));
            check("m_syscall_fire", syscall_fire, int'(expFire));
        end
        if (reset) begin
            armed     = 1;
            mdBusyEnd = cyc;
            sysStart  = -1;
            fireCycle = -1;
        end else begin
            if (fireCycle == cyc) begin
                sysStart  = -1;
                fireCycle = -1;
            end else if (sysStart >= 0 && fireCycle < 0 && cyc >= sysStart + SD && !expBusy) begin
                fireCycle = cyc + 1;
            end else if (sysStart < 0 && syscallD) begin
                sysStart = cyc;
            end
            if (MdStartE) mdBusyEnd = cyc + ML;
        end
        cyc++;
    end

    task automatic clearIn();
        {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {UsesRsD, UsesRtD, BranchD, ReadsHiLoD, syscallD} = '0;
        {RegWriteE, MemtoRegE, MdStartE, RegWriteM, MemtoRegM, RegWriteW} = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        clearIn();
        repeat (n) step();
    endtask

    initial begin
        int s4a[6] = '{0, 1, 1, 1, 1, 0};
        int s4b[8] = '{0, 1, 1, 1, 1, 1, 1, 0};
        int s5a[6] = '{1, 1, 1, 1, 1, 0};
        int f5a[6] = '{0, 0, 0, 0, 1, 0};
        int s5b[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        int f5b[8] = '{0, 0, 0, 0, 0, 0, 1, 0};

        clearIn();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        #2;
        check("rst_StallF", StallF, 0);
        check("rst_ForwardAE", ForwardAE, 0);
        check("rst_md_busy", md_busy, 0);
        check("rst_syscall_fire", syscall_fire, 0);

        // Forwarding priority M over W, then W only
        step();
        RegWriteM = 1; WriteRegM = 8; RegWriteW = 1; WriteRegW = 8; RsE = 8; RtE = 8;
        #2;
        check("fwd_AE_M", ForwardAE, 2);
        check("fwd_BE_M", ForwardBE, 2);
        step();
        RegWriteM = 0;
        #2;
        check("fwd_AE_W", ForwardAE, 1);

        // Register 0 never forwards
        idle(1);
        RegWriteM = 1; WriteRegM = 0; RsE = 0; RtE = 0; RsD = 0;
        RegWriteW = 1; WriteRegW = 0;
        #2;
        check("r0_AE", ForwardAE, 0);
        check("r0_BE", ForwardBE, 0);
        check("r0_AD", ForwardAD, 0);
        step();
        WriteRegM = 5; RsD = 5; RtD = 6;
        #2;
        check("fwd_AD", ForwardAD, 1);
        check("fwd_BD", ForwardBD, 0);

        // Load-use stall
        idle(1);
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 9; RtD = 9; UsesRtD = 1;
        #2;
        check("lw_stall", StallF, 1);
        check("lw_flush", FlushE, 1);
        step();
        UsesRtD = 0;
        #2;
        check("lw_unused", StallD, 0);

        // Branch stalls: ALU result in E, load in M
        idle(1);
        BranchD = 1; RegWriteE = 1; WriteRegE = 7; RsD = 7;
        #2;
        check("br_E", StallF, 1);
        step();
        RegWriteE = 0; MemtoRegM = 1; WriteRegM = 4; RtD = 4;
        #2;
        check("br_M", StallF, 1);
        step();
        BranchD = 0;
        #2;
        check("br_off", StallF, 0);

        // HI/LO interlock: single issue, then reissue in the 2nd busy cycle
        idle(1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            ReadsHiLoD = 1; MdStartE = (i == 0);
            #2;
            check($sformatf("hl_a%0d", i), StallF, s4a[i]);
        end
        idle(2);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            ReadsHiLoD = 1; MdStartE = (i == 0 || i == 2);
            #2;
            check($sformatf("hl_b%0d", i), StallF, s4b[i]);
            check($sformatf("hl_busy%0d", i), md_busy, s4b[i]);
        end

        // Syscall drain, plain and waiting on HI/LO
        idle(2);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            syscallD = (i == 0);
            #2;
            check($sformatf("sys_a_stall%0d", i), StallF, s5a[i]);
            check($sformatf("sys_a_fire%0d", i), syscall_fire, f5a[i]);
        end
        idle(2);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            syscallD = (i == 0); MdStartE = (i == 0);
            #2;
            check($sformatf("sys_b_stall%0d", i), StallF, s5b[i]);
            check($sformatf("sys_b_fire%0d", i), syscall_fire, f5b[i]);
        end
        // Reissue during drain pushes the fire out; the model tracks it
        idle(2);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step();
            syscallD = (i == 0); MdStartE = (i == 3);
        end

        // syscallD held through the drain plus a load-use hazard: single fire at cycle 4
        idle(2);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            syscallD = (i <= 4);
            MemtoRegE = (i <= 1); RegWriteE = (i <= 1); WriteRegE = 3; RsD = 3; UsesRsD = 1;
            #2;
            check($sformatf("sys_c_fire%0d", i), syscall_fire, int'(i == 4));
        end

        // Reset during DRAIN: no fire, busy cleared
        idle(2);
        syscallD = 1; MdStartE = 1;
        step();
        syscallD = 0; MdStartE = 0; reset = 1;
        #2;
        check("rst_drain_stall", StallF, 1);
        step();
        reset = 0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            #2;
            check($sformatf("rst_after_stall%0d", i), StallF, 0);
            check($sformatf("rst_after_fire%0d", i), syscall_fire, 0);
            check($sformatf("rst_after_busy%0d", i), md_busy, 0);
        end

        idle(2);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
